// File: rtl/otg_hpi_sequencer.sv
// Avalon-MM slave to Cypress OTG HPI bus sequencer: stretches each Avalon access
// into a setup / strobe / hold / recover cycle on the HPI pins.
module otg_hpi_sequencer #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC);
    localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC);
    localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC);
    localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] count;
    logic [3:0] count_nxt;
    logic       is_write;
    logic       dir_nxt;
    logic       request;
    logic       accept;
    logic       last_cycle;
    logic       active_nxt;

    assign request    = chipselect & (read | write);
    assign accept     = (state == ST_IDLE) && request;
    assign last_cycle = (count == 4'd1);
    assign dir_nxt    = accept ? write : is_write;
    assign active_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                        (state_nxt == ST_HOLD);

    // The counter holds the cycles left in the current state, including this one.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            ST_IDLE: begin
                count_nxt = 4'd0;
                if (request) begin
                    state_nxt = ST_SETUP;
                    count_nxt = SETUP_LD;
                end
            end
            ST_SETUP: begin
                count_nxt = count - 4'd1;
                if (last_cycle) begin
                    state_nxt = ST_STROBE;
                    count_nxt = STROBE_LD;
                end
            end
            ST_STROBE: begin
                count_nxt = count - 4'd1;
                if (last_cycle) begin
                    state_nxt = ST_HOLD;
                    count_nxt = HOLD_LD;
                end
            end
            ST_HOLD: begin
                count_nxt = count - 4'd1;
                if (last_cycle) begin
                    state_nxt = ST_RECOVER;
                    count_nxt = RECOVER_LD;
                end
            end
            ST_RECOVER: begin
                count_nxt = count - 4'd1;
                if (last_cycle) begin
                    state_nxt = ST_IDLE;
                    count_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = 4'd0;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so every HPI pin comes straight off a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            count        <= 4'd0;
            is_write     <= 1'b0;
            otg_addr     <= 2'd0;
            otg_data_out <= 16'd0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_oe  <= 1'b0;
            waitrequest  <= 1'b1;
            readdata     <= 16'd0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            is_write    <= dir_nxt;
            if (accept) begin
                otg_addr     <= address;
                otg_data_out <= writedata;
            end
            otg_cs_n    <= ~active_nxt;
            otg_rd_n    <= ~((state_nxt == ST_STROBE) && !dir_nxt);
            otg_wr_n    <= ~((state_nxt == ST_STROBE) && dir_nxt);
            otg_data_oe <= active_nxt && dir_nxt;
            waitrequest <= ~((state_nxt == ST_HOLD) && (count_nxt == 4'd1));
            if ((state == ST_STROBE) && last_cycle && !is_write) begin
                readdata <= otg_data_in;
            end
        end
    end

endmodule

// File: tb/tb_otg_hpi_sequencer.sv
// Scoreboard bench for otg_hpi_sequencer: default-parameter instance plus a
// second instance with SETUP=2, STROBE=1, HOLD=3, RECOVER=1.
module tb_otg_hpi_sequencer;

    localparam int LAT = 1 + 4 + 1;
    localparam int RECOVER = 2;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        chipselect2;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;
    logic [1:0]  otg_addr;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic [15:0] readdata2;
    logic        waitrequest2;
    logic [1:0]  otg_addr2;
    logic [15:0] otg_data_out2;
    logic        otg_data_oe2;
    logic        otg_cs_n2;
    logic        otg_rd_n2;
    logic        otg_wr_n2;
    logic [15:0] pad_value;

    typedef struct {
        logic        is_write;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] last_read;
    int          checks;
    int          errors;
    int          cs_low;
    int          wr_low;
    int          rd_low;
    int          oe_cnt;

    otg_hpi_sequencer dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .otg_addr(otg_addr), .otg_data_out(otg_data_out),
        .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in), .otg_cs_n(otg_cs_n),
        .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n)
    );

    otg_hpi_sequencer #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .RECOVER_CYC(1)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect2),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata2),
        .waitrequest(waitrequest2), .otg_addr(otg_addr2), .otg_data_out(otg_data_out2),
        .otg_data_oe(otg_data_oe2), .otg_data_in(otg_data_in), .otg_cs_n(otg_cs_n2),
        .otg_rd_n(otg_rd_n2), .otg_wr_n(otg_wr_n2)
    );

    // The HPI device only drives valid data while its read strobe is low.
    assign otg_data_in = otg_rd_n ? 16'hDEAD : pad_value;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic pushExpected(input logic wr, input logic [1:0] a, input logic [15:0] d, input logic [15:0] pad);
        exp_t e;
        e.is_write = wr;
        e.addr     = a;
        e.wdata    = d;
        if (!wr) last_read = pad;
        e.rdata    = last_read;
        sb.push_back(e);
    endtask

    // Drives one request from IDLE and measures cycles from acceptance to completion.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] a,
                                 input logic [15:0] d, input logic [15:0] pad,
                                 input bit hold_after, input bit scramble);
        int n;
        repeat (RECOVER + 1) @(posedge clk);
        #1;
        pushExpected(wr, a, d, pad);
        pad_value  = pad;
        chipselect = 1'b1;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = d;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (scramble && n == 3) begin
                address   = ~a;
                writedata = ~d;
                read      = 1'b1;
                write     = 1'b0;
            end
            if (!waitrequest) break;
        end
        checkOutput("latency", n - 1, LAT);
        if (!hold_after) begin
            @(posedge clk);
            #1;
            chipselect = 1'b0;
            read       = 1'b0;
            write      = 1'b0;
        end
    endtask

    always @(posedge reset) begin
        cs_low = 0;
        wr_low = 0;
        rd_low = 0;
        oe_cnt = 0;
    end

    // Per-cycle pin monitor; each completion pops and checks one scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("strobe_excl", {31'd0, otg_rd_n | otg_wr_n}, 32'd1);
            checkOutput("oe_vs_rd", {31'd0, otg_data_oe & ~otg_rd_n}, 32'd0);
            if (!otg_cs_n) cs_low++;
            if (!otg_wr_n) wr_low++;
            if (!otg_rd_n) rd_low++;
            if (otg_data_oe) oe_cnt++;
            if (!waitrequest) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("cs_low", cs_low, LAT);
                    checkOutput("addr", {30'd0, otg_addr}, {30'd0, mon_e.addr});
                    checkOutput("readdata", {16'd0, readdata}, {16'd0, mon_e.rdata});
                    if (mon_e.is_write) begin
                        checkOutput("wr_low", wr_low, 4);
                        checkOutput("rd_low_wr", rd_low, 0);
                        checkOutput("oe_cnt_wr", oe_cnt, LAT);
                        checkOutput("data_out", {16'd0, otg_data_out}, {16'd0, mon_e.wdata});
                    end else begin
                        checkOutput("rd_low", rd_low, 4);
                        checkOutput("wr_low_rd", wr_low, 0);
                        checkOutput("oe_cnt_rd", oe_cnt, 0);
                    end
                end
                cs_low = 0;
                wr_low = 0;
                rd_low = 0;
                oe_cnt = 0;
            end
        end
    end

    initial begin
        int n;
        int strobe_cnt;
        checks      = 0;
        errors      = 0;
        last_read   = 16'd0;
        reset       = 1'b1;
        chipselect  = 1'b0;
        chipselect2 = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        address     = 2'd0;
        writedata   = 16'd0;
        pad_value   = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cs_n", {31'd0, otg_cs_n}, 32'd1);
        checkOutput("rst_rd_n", {31'd0, otg_rd_n}, 32'd1);
        checkOutput("rst_wr_n", {31'd0, otg_wr_n}, 32'd1);
        checkOutput("rst_oe", {31'd0, otg_data_oe}, 32'd0);
        checkOutput("rst_addr", {30'd0, otg_addr}, 32'd0);
        checkOutput("rst_data_out", {16'd0, otg_data_out}, 32'd0);
        checkOutput("rst_readdata", {16'd0, readdata}, 32'd0);
        checkOutput("rst_wait", {31'd0, waitrequest}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 2'd2, 16'h1234, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd1, 16'h5A5A, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd3, 16'h0F0F, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd3, 16'h0000, 16'h1357, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 2'd1, 16'hC0DE, 16'h0000, 1'b1, 1'b0);
        pushExpected(1'b1, 2'd1, 16'hC0DE, 16'h0000);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) checkOutput("b2b_recover_cs_n", {31'd0, otg_cs_n}, 32'd1);
            if (!waitrequest) break;
        end
        checkOutput("b2b_gap", n, 9);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;

        repeat (RECOVER + 1) @(posedge clk);
        #1;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 2'd2;
        writedata  = 16'h9999;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!otg_wr_n) n++;
            if (n == 3) break;
        end
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_cs_n", {31'd0, otg_cs_n}, 32'd1);
        checkOutput("rst_mid_wr_n", {31'd0, otg_wr_n}, 32'd1);
        checkOutput("rst_mid_oe", {31'd0, otg_data_oe}, 32'd0);
        checkOutput("rst_mid_wait", {31'd0, waitrequest}, 32'd1);
        chipselect = 1'b0;
        write      = 1'b0;
        last_read  = 16'd0;
        #1;
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            checkOutput("rst_no_done", {31'd0, waitrequest}, 32'd1);
        end
        checkOutput("rst_readdata_clr", {16'd0, readdata}, 32'd0);

        applyStimulus(1'b1, 1'b0, 2'd0, 16'hAA55, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd2, 16'h0000, 16'h2468, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chipselect2 = 1'b1;
        write       = 1'b1;
        address     = 2'd1;
        writedata   = 16'h7777;
        n = 0;
        strobe_cnt = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (!otg_wr_n2) strobe_cnt++;
            if (!waitrequest2) break;
        end
        checkOutput("p_latency", n - 1, 6);
        checkOutput("p_strobe", strobe_cnt, 1);
        checkOutput("p_addr", {30'd0, otg_addr2}, 32'd1);
        checkOutput("p_data_out", {16'd0, otg_data_out2}, 32'h7777);
        @(posedge clk);
        #1;
        chipselect2 = 1'b0;
        write       = 1'b0;
        repeat (4) @(posedge clk);

        checkOutput("sb_leftover", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
